// File: rtl/pr_dec_pkg.sv
// pr_dec_pkg -- shared definitions for the 3-to-8 priority-code decoder.
//   state_t      : FSM state encoding (S_IDLE / S_DRIVE / S_GAP)
//   HOLD_CYC_DEF : default number of cycles a decoded one-hot output is held
//   CNT_W        : width of the hold counter (covers HOLD_CYC up to 15)
//   OUT_W        : width of the one-hot output and the completion counter
//   onehot8()    : 3-bit code to 8-bit one-hot helper
package pr_dec_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int unsigned HOLD_CYC_DEF = 4;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned OUT_W        = 8;

  function automatic logic [OUT_W-1:0] onehot8(input logic [2:0] code);
    return OUT_W'(1) << code;
  endfunction

endpackage

// File: rtl/pr_dec_if.sv
// pr_dec_if -- bus between a priority-encoder style sender and pr_dec.
//   Sender -> decoder : in0..in2 (code, in0 = LSB), idle, valid, clear
//   Decoder -> sender : ready, out (one-hot), done (pulse), count
// Handshake: a transfer happens on a rising clock edge where valid=1 and
// ready=1 (and clear=0). While ready=0 the sender holds valid and the code
// stable; valid seen while ready=0 has no effect.
interface pr_dec_if;
  import pr_dec_pkg::*;

  logic             in0;
  logic             in1;
  logic             in2;
  logic             idle;
  logic             valid;
  logic             clear;
  logic             ready;
  logic [OUT_W-1:0] out;
  logic             done;
  logic [OUT_W-1:0] count;

  modport master (
    output in0, in1, in2, idle, valid, clear,
    input  ready, out, done, count
  );

  modport slave (
    input  in0, in1, in2, idle, valid, clear,
    output ready, out, done, count
  );

endinterface

// File: rtl/pr_hold_cnt.sv
// pr_hold_cnt -- down-counter that times how long a decoded output is held.
//   i_clk      : rising-edge clock
//   i_rst_n    : asynchronous active-low reset (counter -> 0)
//   i_clear    : synchronous clear (highest priority after reset)
//   i_load     : load i_load_val
//   i_load_val : value to load
//   i_dec      : decrement by one; saturates at zero
//   o_zero     : counter currently equals zero
module pr_hold_cnt
  import pr_dec_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pr_dec.sv
// pr_dec -- decodes a 3-bit priority code into a registered one-hot output
// held for HOLD_CYC cycles, followed by a one-cycle gap carrying a done
// pulse and a completion-count increment.
//   HOLD_CYC : cycles the one-hot output is held (1..15)
//   i_clk    : rising-edge clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : pr_dec_if slave (code/idle/valid/clear in; ready/out/done/count out)
//   o_state  : current FSM state, for observation only
module pr_dec
  import pr_dec_pkg::*;
#(
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  pr_dec_if.slave  bus,
  output state_t   o_state
);

  // Counter starts at HOLD_CYC-1 and S_DRIVE exits on zero, giving exactly
  // HOLD_CYC cycles in S_DRIVE.
  localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(HOLD_CYC - 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_code;
  logic [OUT_W-1:0] r_out;
  logic             r_done;
  logic [OUT_W-1:0] r_count;

  logic [2:0]       w_code;
  logic [2:0]       w_next_code;
  logic             w_ready;
  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_cnt_dec;

  assign w_code  = {bus.in2, bus.in1, bus.in0};
  assign w_ready = (r_state == S_IDLE);
  // Clear wins over a simultaneous transfer; an idle transfer is consumed
  // without starting a transaction.
  assign w_accept    = bus.valid && w_ready && !bus.clear && !bus.idle;
  assign w_next_code = w_accept ? w_code : r_code;
  assign w_cnt_dec   = (r_state == S_DRIVE);

  pr_hold_cnt u_hold_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (bus.clear),
    .i_load     (w_accept),
    .i_load_val (LP_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_next = S_DRIVE;
      S_DRIVE: if (w_cnt_zero) w_next = S_GAP;
      S_GAP:                   w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
    if (bus.clear) begin
      w_next = S_IDLE;
    end
  end

  // Outputs are computed from the next state so they line up with the
  // state they belong to while still coming straight out of flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code  <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_code <= w_code;
      end
      r_out  <= (w_next == S_DRIVE) ? onehot8(w_next_code) : '0;
      r_done <= (w_next == S_GAP);
      if (w_next == S_GAP) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.ready = w_ready;
  assign bus.out   = r_out;
  assign bus.done  = r_done;
  assign bus.count = r_count;
  assign o_state   = r_state;

endmodule
